seg7_scan_ctrl: RTL
===================

# seg7_scan_ctrl

Eight-digit multiplexed seven-segment scan controller for the Nexys4 DDR board top. It replaces the free-running counter decode in the top level. A host (the confreg or a debug source) writes 32-bit hex data, a digit enable mask and a brightness value through a valid/ready port. The block double-buffers the write, commits it only at frame boundaries, and drives the board's active-low anodes and segments with inter-digit blanking (anti-ghosting) and PWM dimming.

## Interface
- DIGIT_CYCLES, 20: clock cycles per digit slot (blank + drive). Constraint: BLANK_CYCLES < DIGIT_CYCLES ≤ 2^20.
- BLANK_CYCLES, 4: cycles at the start of each slot with all anodes off. Must be ≥ 1.

- clk  in  1  system clock
- resetn  in  1  reset, synchronous, active-low
- wr_valid  in  1  host write request
- wr_ready  out  1  block can accept a write
- wr_data  in  32  nibble i (wr_data[4i+3:4i]) is the hex value of digit i
- wr_mask  in  8  bit i = 1 enables digit i
- wr_bright  in  4  PWM duty, brightness/16
- an  out  8  anodes, active-low, bit i = digit i
- seg  out  7  segments, active-low, bit6 = g … bit0 = a
- frame_done  out  1  one-cycle pulse at each frame boundary

## Operation
- Registers:
  - Pending buffer: pend_valid, pend_data, pend_mask, pend_bright.
  - Shadow (displayed) set: sh_data, sh_mask, sh_bright.
  - Digit index idx (3 bits), slot counter cnt, free-running 4-bit pwm_cnt.
  - State: BLANK or DRIVE.
- Handshake: wr_ready = ~pend_valid. A transfer occurs when wr_valid & wr_ready. It loads the pending buffer and sets pend_valid. No other input is sampled outside a transfer.
- State machine, per slot:
  - BLANK: lasts BLANK_CYCLES cycles, then goes to DRIVE.
  - DRIVE: lasts DIGIT_CYCLES − BLANK_CYCLES cycles, then goes to BLANK with idx+1. idx wraps 7→0.
  - cnt counts 0..DIGIT_CYCLES−1 and resets to 0 at slot end.
- Frame boundary is the last DRIVE cycle of idx 7. In that cycle:
  - frame_done = 1.
  - If pend_valid: shadow ← pending, pend_valid clears, wr_ready = 1 the next cycle.
  - A transfer accepted in the boundary cycle itself lands in pending and commits at the following boundary.
- Drive decode, applied to the registered outputs:
  - BLANK: an = 8'hFF, seg = 7'h7F.
  - DRIVE: an[idx] = 0 only if sh_mask[idx] & (pwm_cnt < sh_bright); all other anodes are 1.
  - seg = hex decode of sh_data nibble idx. Values: 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0010000, A:0001000, B:0000011, C:1000110, D:0100001, E:0000110, F:0001110.
  - A digit with mask 0 or brightness 0 is always dark.
- pwm_cnt increments every cycle, wraps 15→0, and runs through BLANK and DRIVE alike.

## Timing
- Reset values:
  - an = 8'hFF, seg = 7'h7F, wr_ready = 1, frame_done = 0.
  - idx = 0, state BLANK, cnt = 0, pwm_cnt = 0, pend_valid = 0.
  - sh_data = 0, sh_mask = 8'h00, sh_bright = 0.
- an and seg are registered: their value in cycle t+1 reflects state, idx and pwm_cnt in cycle t.
- Write-to-display latency:
  - Transfer to shadow commit: up to one frame (8·DIGIT_CYCLES cycles).
  - Shadow commit to first possible lit digit 0: BLANK_CYCLES + 1 cycles.
- Frame length is exactly 8·DIGIT_CYCLES cycles, and frame_done pulses once per frame.
- A reset asserted mid-frame or with a write pending discards pending and shadow contents. Outputs return to reset values on the next clock edge.
- wr_valid may be held while wr_ready = 0. Data must be held stable until the transfer occurs.

## Test plan
All scenarios use the default parameters (DIGIT_CYCLES = 20, BLANK_CYCLES = 4, frame = 160 cycles).
- Reset: hold resetn = 0 for 3 cycles → an = 8'hFF, seg = 7'h7F, wr_ready = 1, frame_done = 0. an stays 8'hFF for a full 160-cycle frame after release (mask 0).
- Write 32'h76543210, mask 8'hFF, bright 15 → after the next frame_done:
  - Digit 0 slot: an = 8'hFF for 4 cycles, then an = 8'hFE with seg = 1000000 in exactly 15 of its 16 drive cycles.
  - Digit 3 slot shows seg = 0110000.
- Back-pressure:
  - Two back-to-back writes (A then B) → wr_ready = 0 after A.
  - B is held and accepted the cycle after the frame_done that commits A.
  - A is displayed for exactly one full frame before B.
- Mask 8'h0F with bright 15 → an[7:4] = 4'hF for the entire frame; an[3:0] toggle per slot.
- PWM: bright 8 → each enabled digit lit exactly 8 cycles per slot. Bright 0 → an = 8'hFF for the whole frame.
- Reset mid-frame with a write pending → outputs return to reset values next cycle, wr_ready = 1, and the pending data never appears.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scan controller with a double-buffered
// host write port, inter-digit blanking and PWM dimming.
module seg7_scan_ctrl #(
    parameter int DIGIT_CYCLES = 20,
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    input  logic [7:0]  wr_mask,
    input  logic [3:0]  wr_bright,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        frame_done
);

    localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [3:0]    pwm_cnt;

    logic          pend_valid;
    logic [31:0]   pend_data;
    logic [7:0]    pend_mask;
    logic [3:0]    pend_bright;

    logic [31:0]   sh_data;
    logic [7:0]    sh_mask;
    logic [3:0]    sh_bright;

    logic [3:0]    nibble;
    logic          lit;
    logic          boundary;

    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        case (v)
            4'h0: hex_decode = 7'b1000000;
            4'h1: hex_decode = 7'b1111001;
            4'h2: hex_decode = 7'b0100100;
            4'h3: hex_decode = 7'b0110000;
            4'h4: hex_decode = 7'b0011001;
            4'h5: hex_decode = 7'b0010010;
            4'h6: hex_decode = 7'b0000010;
            4'h7: hex_decode = 7'b1111000;
            4'h8: hex_decode = 7'b0000000;
            4'h9: hex_decode = 7'b0010000;
            4'hA: hex_decode = 7'b0001000;
            4'hB: hex_decode = 7'b0000011;
            4'hC: hex_decode = 7'b1000110;
            4'hD: hex_decode = 7'b0100001;
            4'hE: hex_decode = 7'b0000110;
            default: hex_decode = 7'b0001110;
        endcase
    endfunction

    assign wr_ready   = ~pend_valid;
    assign boundary   = (state == DRIVE) && (idx == 3'd7) && (cnt == CNT_LAST);
    assign frame_done = boundary;

    always_comb begin
        nibble = sh_data[{idx, 2'b00} +: 4];
        lit    = sh_mask[idx] && (pwm_cnt < sh_bright);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= BLANK;
            cnt         <= '0;
            idx         <= 3'd0;
            pwm_cnt     <= 4'd0;
            pend_valid  <= 1'b0;
            pend_data   <= 32'd0;
            pend_mask   <= 8'd0;
            pend_bright <= 4'd0;
            sh_data     <= 32'd0;
            sh_mask     <= 8'd0;
            sh_bright   <= 4'd0;
            an          <= 8'hFF;
            seg         <= 7'h7F;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;

            case (state)
                BLANK: begin
                    an  <= 8'hFF;
                    seg <= 7'h7F;
                    cnt <= cnt + 1'b1;
                    if (cnt == BLANK_LAST)
                        state <= DRIVE;
                end
                DRIVE: begin
                    an  <= lit ? ~(8'b1 << idx) : 8'hFF;
                    seg <= hex_decode(nibble);
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= BLANK;
                        idx   <= idx + 3'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= BLANK;
            endcase

            // Commit and accept never coincide: a transfer needs pend_valid low.
            if (boundary && pend_valid) begin
                sh_data    <= pend_data;
                sh_mask    <= pend_mask;
                sh_bright  <= pend_bright;
                pend_valid <= 1'b0;
            end else if (wr_valid && !pend_valid) begin
                pend_data   <= wr_data;
                pend_mask   <= wr_mask;
                pend_bright <= wr_bright;
                pend_valid  <= 1'b1;
            end
        end
    end

endmodule
